sequence_detector_param: RTL

Parametrised serial pattern detector, successor to the fixed 110 detector. It compares a serial bit stream `si` against a runtime-loadable pattern of PATTERN_WIDTH bits. It supports overlapping and non-overlapping detection, an input-enable qualifier, and a saturating match counter. It sits between a serial data source (PRBS / deserialiser) and control logic that consumes the `detected` pulse or reads `count`.

---
 rtl/sequence_detector_param.sv | 97 +++++++++
 1 files changed

// File: rtl/sequence_detector_param.sv
// ============================================================================
// Module   : sequence_detector_param
// Purpose  : Serial pattern detector with a loadable pattern, overlap control,
//            input-enable gating and a saturating match counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sequence_detector_param #(
  parameter int                       PATTERN_WIDTH   = 3,
  parameter logic [PATTERN_WIDTH-1:0] PATTERN_DEFAULT = 3'b110,
  parameter int                       COUNT_WIDTH     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     si,
  input  logic [PATTERN_WIDTH-1:0] pattern_in,
  input  logic                     load,
  input  logic                     overlap,
  input  logic                     clear,
  output logic                     detected,
  output logic [COUNT_WIDTH-1:0]   count,
  output logic                     saturated
);

  localparam int                     c_fill_w  = $clog2(PATTERN_WIDTH + 1);
  localparam logic [c_fill_w-1:0]    c_full    = c_fill_w'(PATTERN_WIDTH);
  localparam logic [c_fill_w-1:0]    c_fill_one = c_fill_w'(1);
  localparam logic [COUNT_WIDTH-1:0] c_cnt_max = '1;
  localparam logic [COUNT_WIDTH-1:0] c_cnt_one = COUNT_WIDTH'(1);

  logic [PATTERN_WIDTH-1:0] r_pat;
  logic [PATTERN_WIDTH-1:0] r_win;
  logic [c_fill_w-1:0]      r_fill;
  logic                     r_detected;
  logic [COUNT_WIDTH-1:0]   r_count;
  logic                     r_saturated;

  logic [PATTERN_WIDTH-1:0] w_nw;
  logic [c_fill_w-1:0]      w_nf;
  logic                     w_match;
  logic [COUNT_WIDTH-1:0]   w_cnt_next;

  // Next window/fill as if this edge consumes si; the match uses these values.
  always_comb begin
    w_nw       = {r_win[PATTERN_WIDTH-2:0], si};
    w_nf       = (r_fill == c_full) ? r_fill : r_fill + c_fill_one;
    w_match    = (w_nf == c_full) && (w_nw == r_pat);
    w_cnt_next = (r_count == c_cnt_max) ? r_count : r_count + c_cnt_one;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pat       <= PATTERN_DEFAULT;
      r_win       <= '0;
      r_fill      <= '0;
      r_detected  <= 1'b0;
      r_count     <= '0;
      r_saturated <= 1'b0;
    end else if (clear || load) begin
      // Either strobe flushes history; si is ignored on this edge.
      r_win      <= '0;
      r_fill     <= '0;
      r_detected <= 1'b0;
      if (clear) begin
        r_count     <= '0;
        r_saturated <= 1'b0;
      end
      if (load) begin
        r_pat <= pattern_in;
      end
    end else if (en) begin
      r_win      <= w_nw;
      r_detected <= w_match;
      if (w_match) begin
        r_count <= w_cnt_next;
        if (w_cnt_next == c_cnt_max) begin
          r_saturated <= 1'b1;
        end
        // Non-overlapping mode demands a full set of fresh bits for the next hit.
        r_fill <= overlap ? w_nf : '0;
      end else begin
        r_fill <= w_nf;
      end
    end else begin
      r_detected <= 1'b0;
    end
  end

  assign detected  = r_detected;
  assign count     = r_count;
  assign saturated = r_saturated;

endmodule

`default_nettype wire
